// File: rtl/dsram_pkg.sv
// Shared types and the byte-lane merge used by the data SRAM responder.
package dsram_pkg;

  typedef enum logic {CLEAR, READY} state_t;

  localparam int DSRAM_WORD_BYTES = 4;

  function automatic logic [31:0] merge(input logic [31:0] old_word,
                                        input logic [31:0] new_word,
                                        input logic [DSRAM_WORD_BYTES-1:0] wen);
    logic [31:0] w;
    w = old_word;
    for (int i = 0; i < DSRAM_WORD_BYTES; i++) begin
      if (wen[i]) w[8*i +: 8] = new_word[8*i +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/dsram_array.sv
// Single-port word array with byte-lane writes and a registered read port.
// DSRAM_WRITE_FIRST_EN: a write cycle returns the merged word instead of the old one.
module dsram_array
  import dsram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [DSRAM_WORD_BYTES-1:0] wen,
  input  logic [ADDR_WIDTH-1:0]       addr,
  input  logic [31:0]                 wdata,
  input  logic                        rd_en,
  input  logic                        rd_clr,
  output logic [31:0]                 rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];
  logic [31:0] cur;
  logic [31:0] merged;

  assign cur    = mem[addr];
  assign merged = merge(cur, wdata, wen);

  always_ff @(posedge clk) begin
    if (en && (wen != '0)) mem[addr] <= merged;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_clr) begin
      rdata <= '0;
    end else if (rd_en) begin
`ifdef DSRAM_WRITE_FIRST_EN
      rdata <= merged;
`else
      rdata <= cur;
`endif
    end
  end

endmodule

// File: rtl/dsram_responder.sv
// CPU data SRAM responder: post-reset clear sweep, range check, 1-cycle read latency.
// DSRAM_WRITE_FIRST_EN selects write-first read data (default read-first), see dsram_array.
module dsram_responder
  import dsram_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] CLEAR_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        dsram_ready,
  output logic        dsram_addr_err
);

  localparam int                    DEPTH    = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  state_t                          state;
  logic [ADDR_WIDTH-1:0]           clr_cnt;
  logic [ADDR_WIDTH-1:0]           idx;
  logic                            in_range;
  logic                            host_acc;
  logic                            host_bad;
  logic                            arr_en;
  logic [DSRAM_WORD_BYTES-1:0]     arr_wen;
  logic [ADDR_WIDTH-1:0]           arr_addr;
  logic [31:0]                     arr_wdata;
  logic                            unused_addr_bits;

  // Byte offset bits carry no meaning for a word-wide port.
  assign unused_addr_bits = ^data_sram_addr[1:0];

  assign idx      = data_sram_addr[ADDR_WIDTH+1:2];
  assign in_range = (data_sram_addr[31:ADDR_WIDTH+2] == '0);
  assign host_acc = (state == READY) && data_sram_en && in_range;
  assign host_bad = (state == READY) && data_sram_en && !in_range;

  // The sweep owns the array port until it finishes; host requests are dropped.
  assign arr_en    = (state == CLEAR) || host_acc;
  assign arr_wen   = (state == CLEAR) ? '1 : data_sram_wen;
  assign arr_addr  = (state == CLEAR) ? clr_cnt : idx;
  assign arr_wdata = (state == CLEAR) ? CLEAR_VALUE : data_sram_wdata;

  dsram_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk    (clk),
    .rst_n  (resetn),
    .en     (arr_en),
    .wen    (arr_wen),
    .addr   (arr_addr),
    .wdata  (arr_wdata),
    .rd_en  (host_acc),
    .rd_clr (host_bad),
    .rdata  (data_sram_rdata)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= CLEAR;
      clr_cnt        <= '0;
      dsram_ready    <= 1'b0;
      dsram_addr_err <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt        <= clr_cnt + 1'b1;
          dsram_addr_err <= 1'b0;
          if (clr_cnt == LAST_IDX) begin
            state       <= READY;
            dsram_ready <= 1'b1;
          end
        end
        READY: begin
          dsram_addr_err <= host_bad;
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsram_responder.sv
// Randomized scoreboard bench for dsram_responder against a word-array reference model.
module tb_dsram_responder;

  localparam int          AW    = 4;
  localparam int          DEPTH = 16;
  localparam logic [31:0] CV    = 32'h0000_0000;
`ifdef DSRAM_WRITE_FIRST_EN
  localparam bit WRITE_FIRST = 1'b1;
`else
  localparam bit WRITE_FIRST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        dsram_ready;
  logic        dsram_addr_err;

  dsram_responder #(
    .ADDR_WIDTH  (AW),
    .CLEAR_VALUE (CV)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .dsram_ready     (dsram_ready),
    .dsram_addr_err  (dsram_addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mdl_mem [DEPTH];
  logic [31:0] mdl_rdata;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = CV;
    mdl_rdata = 32'h0;
  endtask

  // Drive one request and record the response expected on the following cycle.
  task automatic issue(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata);
    exp_t        e;
    int          w;
    logic [31:0] old_w;
    logic [31:0] new_w;
    @(negedge clk);
    data_sram_en    = en;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    w = int'((addr / 4) % DEPTH);
    e.err = 1'b0;
    if (en && (addr < DEPTH * 4)) begin
      old_w = mdl_mem[w];
      new_w = old_w;
      for (int b = 0; b < 4; b++) begin
        if (wen[b]) new_w[8*b +: 8] = wdata[8*b +: 8];
      end
      mdl_mem[w] = new_w;
      mdl_rdata  = WRITE_FIRST ? new_w : old_w;
    end else if (en) begin
      mdl_rdata = 32'h0;
      e.err     = 1'b1;
    end
    e.rdata = mdl_rdata;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (q.size() > 0) begin
        #1;
        e = q.pop_front();
        check("rdata", data_sram_rdata, e.rdata);
        check("addr_err", {31'b0, dsram_addr_err}, {31'b0, e.err});
        check("ready_hold", {31'b0, dsram_ready}, 32'd1);
      end
    end
  end

  // Called right after resetn rises on a negedge; counts posedges until ready.
  task automatic sweep(input bit junk, output int cycles);
    cycles = -1;
    for (int c = 1; c <= 40; c++) begin
      data_sram_en = junk;
      if (junk) begin
        data_sram_wen   = 4'(($urandom_range(0, 14)) + 1);
        case ($urandom_range(0, 2))
          0:       data_sram_addr = 32'h0;
          1:       data_sram_addr = 32'h3C;
          default: data_sram_addr = $urandom;
        endcase
        data_sram_wdata = $urandom | 32'h1;
      end
      @(posedge clk);
      #1;
      check("sweep_rdata", data_sram_rdata, 32'h0);
      check("sweep_err", {31'b0, dsram_addr_err}, 32'd0);
      if (dsram_ready) begin
        cycles = c;
        break;
      end
      @(negedge clk);
    end
    data_sram_en = 1'b0;
    if (cycles < 0) begin
      errors++;
      $display("FAIL sweep_timeout actual=not_ready required=ready");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
  endtask

  initial begin : stim
    int n;
    int r;
    logic [31:0] a;
    resetn = 1'b0;
    data_sram_en = 1'b0;
    data_sram_wen = 4'h0;
    data_sram_addr = 32'h0;
    data_sram_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, dsram_ready}, 32'd0);
    check("rst_rdata", data_sram_rdata, 32'h0);
    check("rst_err", {31'b0, dsram_addr_err}, 32'd0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    sweep(1'b0, n);
    check("sweep_len", n, DEPTH);

    issue(1'b1, 4'h0, 32'h0000_003C, 32'hFFFF_FFFF);
    issue(1'b1, 4'hF, 32'h0000_0008, 32'hDEAD_BEEF);
    issue(1'b1, 4'h0, 32'h0000_0008, 32'h0);
    issue(1'b1, 4'b0011, 32'h0000_0008, 32'h1234_5678);
    issue(1'b1, 4'h0, 32'h0000_0008, 32'h0);
    issue(1'b0, 4'h0, 32'h0000_0000, 32'h0);
    issue(1'b1, 4'h0, 32'h0000_0400, 32'h0);
    issue(1'b0, 4'h0, 32'h0000_0000, 32'h0);
    issue(1'b1, 4'hF, 32'h0000_0040, 32'hAAAA_AAAA);
    issue(1'b1, 4'h0, 32'h0000_0000, 32'h0);
    issue(1'b1, 4'hF, 32'h0000_003F, 32'hCAFE_F00D);
    issue(1'b1, 4'h0, 32'h0000_003C, 32'h0);
    issue(1'b1, 4'b1100, 32'hFFFF_FFC0, 32'h5555_5555);

    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'h40 + 32'($urandom_range(0, 255));
      else             a = 32'($urandom_range(0, DEPTH * 4 - 1));
      issue(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), a, $urandom);
    end
    issue(1'b1, 4'hF, 32'h0000_0010, 32'h8765_4321);
    issue(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    drain();

    // Reset while operating, then again partway through the restarted sweep.
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("op_rst_ready", {31'b0, dsram_ready}, 32'd0);
    check("op_rst_rdata", data_sram_rdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("mid_rst_ready", {31'b0, dsram_ready}, 32'd0);
    check("mid_rst_rdata", data_sram_rdata, 32'h0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    sweep(1'b1, n);
    check("resweep_len", n, DEPTH);

    for (int i = 0; i < DEPTH; i++) issue(1'b1, 4'h0, 32'(i * 4), 32'h0);
    issue(1'b1, 4'b0101, 32'h0000_0024, 32'h1122_3344);
    issue(1'b1, 4'h0, 32'h0000_0024, 32'h0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
